// File: rtl/motor_io_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// motor_io_conditioner_pkg
// Shared constants and types for the motor I/O conditioning layer that sits
// between the FMC pin mapping and the motor controller core.
//   NUMBER_OF_SWITCHES_PER_MOTOR : raw end-switch bits per motor
//   DEFAULT_*                    : default timing constants for the block
//   mreset_state_t               : state encoding of the driver-reset stretcher
//   motor_cond_t                 : conditioned per-motor status bundle
//   max_int                      : constant helper for width calculations
// ---------------------------------------------------------------------------
package motor_io_conditioner_pkg;

    localparam int NUMBER_OF_SWITCHES_PER_MOTOR = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES      = 16;
    localparam int DEFAULT_RESET_CYCLES         = 1000;
    localparam int DEFAULT_REV_SAMPLE_DELAY     = 16;

    typedef enum logic {
        MRST_IDLE   = 1'b0,
        MRST_ASSERT = 1'b1
    } mreset_state_t;

    typedef struct packed {
        logic [NUMBER_OF_SWITCHES_PER_MOTOR-1:0] switches;
        logic                                    fail;
        logic                                    failLatched;
    } motor_cond_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
// One asynchronous input bit: 2-flop synchroniser, optional inversion and a
// stability debouncer. The output toggles only after the synchronised value
// has differed from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   Clk_ik      in  system clock
//   Rst_irn     in  asynchronous active-low reset
//   Raw_i       in  asynchronous raw pin
//   Debounced_o out debounced, optionally inverted level
// ---------------------------------------------------------------------------
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int INVERT          = 1
) (
    input  logic Clk_ik,
    input  logic Rst_irn,
    input  logic Raw_i,
    output logic Debounced_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             INV_BIT  = (INVERT != 0);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_synced;

    assign w_synced = r_sync2 ^ INV_BIT;

    // The counter only accumulates while the input disagrees with the
    // debounced level; any agreement wipes it, so glitches earn no credit.
    always_ff @(posedge Clk_ik or negedge Rst_irn) begin
        if (!Rst_irn) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= Raw_i;
            r_sync2 <= r_sync1;
            if (w_synced == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign Debounced_o = r_stable;

endmodule

// File: rtl/motor_io_conditioner.sv
// ---------------------------------------------------------------------------
// motor_io_conditioner
// Registered conditioning of per-motor FMC inputs for the motor core.
// Ports:
//   Clk_ik, Rst_irn     clock, asynchronous active-low reset
//   RawSwitches_ib      raw end switches, motor m owns [m*SPM +: SPM]
//   RawFail_ib          raw driver-fail pins
//   FailClear_ib        per-motor clear request for the sticky fail
//   DeactivateReq_ib    StepDeactivate request from the core
//   MResetReq_i         driver reset request pulse
//   PcbRevRaw_ib4       resistor-strapped PCB revision pins
//   Switches_ob         debounced switches
//   Fail_ob             debounced fail level
//   FailLatched_ob      sticky fail flag
//   SwitchEvent_o       one-cycle strobe after any debounced switch change
//   Deactivate_ob       registered deactivate drive (request | auto)
//   MReset_o            stretched driver reset
//   PCBrevision_ob4     revision captured once per reset
//   RevValid_o          revision capture complete
// ---------------------------------------------------------------------------
module motor_io_conditioner
    import motor_io_conditioner_pkg::*;
#(
    parameter int NMOTORS            = 16,
    parameter int SWITCHES_PER_MOTOR = NUMBER_OF_SWITCHES_PER_MOTOR,
    parameter int DEBOUNCE_CYCLES    = DEFAULT_DEBOUNCE_CYCLES,
    parameter int INVERT_INPUTS      = 1,
    parameter int AUTO_DEACTIVATE    = 1,
    parameter int RESET_CYCLES       = DEFAULT_RESET_CYCLES,
    parameter int REV_SAMPLE_DELAY   = DEFAULT_REV_SAMPLE_DELAY
) (
    input  logic                                    Clk_ik,
    input  logic                                    Rst_irn,
    input  logic [NMOTORS*SWITCHES_PER_MOTOR-1:0]   RawSwitches_ib,
    input  logic [NMOTORS-1:0]                      RawFail_ib,
    input  logic [NMOTORS-1:0]                      FailClear_ib,
    input  logic [NMOTORS-1:0]                      DeactivateReq_ib,
    input  logic                                    MResetReq_i,
    input  logic [3:0]                              PcbRevRaw_ib4,
    output logic [NMOTORS*SWITCHES_PER_MOTOR-1:0]   Switches_ob,
    output logic [NMOTORS-1:0]                      Fail_ob,
    output logic [NMOTORS-1:0]                      FailLatched_ob,
    output logic                                    SwitchEvent_o,
    output logic [NMOTORS-1:0]                      Deactivate_ob,
    output logic                                    MReset_o,
    output logic [3:0]                              PCBrevision_ob4,
    output logic                                    RevValid_o
);

    localparam int   NSW       = NMOTORS * SWITCHES_PER_MOTOR;
    localparam int   RST_CNT_W = max_int(1, $clog2(RESET_CYCLES));
    localparam int   REV_CNT_W = max_int(8, $clog2(REV_SAMPLE_DELAY + 1));
    localparam logic AUTO_BIT  = (AUTO_DEACTIVATE != 0);

    // ------------------------------------------------------------------
    // Per-bit synchronise + debounce
    // ------------------------------------------------------------------
    logic [NSW-1:0]     w_switches;
    logic [NMOTORS-1:0] w_fail;

    genvar gi;
    generate
        for (gi = 0; gi < NSW; gi++) begin : g_sw_deb
            input_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .INVERT          (INVERT_INPUTS)
            ) u_deb (
                .Clk_ik      (Clk_ik),
                .Rst_irn     (Rst_irn),
                .Raw_i       (RawSwitches_ib[gi]),
                .Debounced_o (w_switches[gi])
            );
        end
        for (gi = 0; gi < NMOTORS; gi++) begin : g_fail_deb
            input_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .INVERT          (INVERT_INPUTS)
            ) u_deb (
                .Clk_ik      (Clk_ik),
                .Rst_irn     (Rst_irn),
                .Raw_i       (RawFail_ib[gi]),
                .Debounced_o (w_fail[gi])
            );
        end
    endgenerate

    assign Switches_ob = w_switches;
    assign Fail_ob     = w_fail;

    // ------------------------------------------------------------------
    // Switch change strobe: one pulse regardless of how many bits moved
    // ------------------------------------------------------------------
    logic [NSW-1:0] r_sw_prev;
    logic           r_sw_event;

    always_ff @(posedge Clk_ik or negedge Rst_irn) begin
        if (!Rst_irn) begin
            r_sw_prev  <= '0;
            r_sw_event <= 1'b0;
        end else begin
            r_sw_prev  <= w_switches;
            r_sw_event <= (w_switches != r_sw_prev);
        end
    end

    assign SwitchEvent_o = r_sw_event;

    // ------------------------------------------------------------------
    // Sticky fail and deactivate drive
    // ------------------------------------------------------------------
    logic [NMOTORS-1:0] r_fail_latched;
    logic [NMOTORS-1:0] r_deactivate;

    // A clear is honoured only once the live fail has gone; a live fail
    // always sets, so set beats clear when both happen together.
    always_ff @(posedge Clk_ik or negedge Rst_irn) begin
        if (!Rst_irn) begin
            r_fail_latched <= '0;
            r_deactivate   <= '0;
        end else begin
            r_fail_latched <= w_fail | (r_fail_latched & ~(FailClear_ib & ~w_fail));
            r_deactivate   <= DeactivateReq_ib | ({NMOTORS{AUTO_BIT}} & r_fail_latched);
        end
    end

    assign FailLatched_ob = r_fail_latched;
    assign Deactivate_ob  = r_deactivate;

    // ------------------------------------------------------------------
    // Driver reset stretcher
    // Resets into ASSERT so the drivers stay in reset during and for
    // RESET_CYCLES after block reset.
    // ------------------------------------------------------------------
    mreset_state_t          r_mrst_state;
    mreset_state_t          w_mrst_state_next;
    logic [RST_CNT_W-1:0]   r_mrst_cnt;
    logic [RST_CNT_W-1:0]   w_mrst_cnt_next;
    logic                   w_mreset;

    always_ff @(posedge Clk_ik or negedge Rst_irn) begin
        if (!Rst_irn) begin
            r_mrst_state <= MRST_ASSERT;
            r_mrst_cnt   <= '0;
        end else begin
            r_mrst_state <= w_mrst_state_next;
            r_mrst_cnt   <= w_mrst_cnt_next;
        end
    end

    always_comb begin
        w_mrst_state_next = r_mrst_state;
        w_mrst_cnt_next   = r_mrst_cnt;
        case (r_mrst_state)
            MRST_IDLE: begin
                if (MResetReq_i) begin
                    w_mrst_state_next = MRST_ASSERT;
                    w_mrst_cnt_next   = '0;
                end
            end
            MRST_ASSERT: begin
                // A new request restarts the count, extending the pulse.
                if (MResetReq_i) begin
                    w_mrst_cnt_next = '0;
                end else if (r_mrst_cnt == RST_CNT_W'(RESET_CYCLES - 1)) begin
                    w_mrst_state_next = MRST_IDLE;
                    w_mrst_cnt_next   = '0;
                end else begin
                    w_mrst_cnt_next = r_mrst_cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        w_mreset = (r_mrst_state == MRST_ASSERT);
    end

    assign MReset_o = w_mreset;

    // ------------------------------------------------------------------
    // PCB revision capture: sampled once, REV_SAMPLE_DELAY cycles after
    // reset release, then frozen until the next reset.
    // ------------------------------------------------------------------
    logic [3:0]           r_rev_sync1;
    logic [3:0]           r_rev_sync2;
    logic [REV_CNT_W-1:0] r_rev_cnt;
    logic [3:0]           r_pcb_rev;
    logic                 r_rev_valid;

    always_ff @(posedge Clk_ik or negedge Rst_irn) begin
        if (!Rst_irn) begin
            r_rev_sync1 <= '0;
            r_rev_sync2 <= '0;
            r_rev_cnt   <= '0;
            r_pcb_rev   <= '0;
            r_rev_valid <= 1'b0;
        end else begin
            r_rev_sync1 <= PcbRevRaw_ib4;
            r_rev_sync2 <= r_rev_sync1;
            if (!r_rev_valid) begin
                if (r_rev_cnt == REV_CNT_W'(REV_SAMPLE_DELAY)) begin
                    r_pcb_rev   <= r_rev_sync2;
                    r_rev_valid <= 1'b1;
                end else begin
                    r_rev_cnt <= r_rev_cnt + 1'b1;
                end
            end
        end
    end

    assign PCBrevision_ob4 = r_pcb_rev;
    assign RevValid_o      = r_rev_valid;

endmodule

// File: tb/tb_motor_io_conditioner.sv
module tb_motor_io_conditioner;

    localparam int NM  = 16;
    localparam int SPM = 2;
    localparam int NSW = NM * SPM;
    localparam int DEB = 4;
    localparam int RC  = 1000;
    localparam int RSD = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NSW-1:0] raw_sw;
    logic [NM-1:0]  raw_fail;
    logic [NM-1:0]  fail_clr;
    logic [NM-1:0]  deact_req;
    logic           mres_req;
    logic [3:0]     rev_raw;

    logic [NSW-1:0] sw;
    logic [NM-1:0]  fail;
    logic [NM-1:0]  fail_lat;
    logic           sw_evt;
    logic [NM-1:0]  deact;
    logic           mreset;
    logic [3:0]     pcb_rev;
    logic           rev_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    motor_io_conditioner #(
        .NMOTORS            (NM),
        .SWITCHES_PER_MOTOR (SPM),
        .DEBOUNCE_CYCLES    (DEB),
        .INVERT_INPUTS      (1),
        .AUTO_DEACTIVATE    (1),
        .RESET_CYCLES       (RC),
        .REV_SAMPLE_DELAY   (RSD)
    ) dut (
        .Clk_ik           (clk),
        .Rst_irn          (rst_n),
        .RawSwitches_ib   (raw_sw),
        .RawFail_ib       (raw_fail),
        .FailClear_ib     (fail_clr),
        .DeactivateReq_ib (deact_req),
        .MResetReq_i      (mres_req),
        .PcbRevRaw_ib4    (rev_raw),
        .Switches_ob      (sw),
        .Fail_ob          (fail),
        .FailLatched_ob   (fail_lat),
        .SwitchEvent_o    (sw_evt),
        .Deactivate_ob    (deact),
        .MReset_o         (mreset),
        .PCBrevision_ob4  (pcb_rev),
        .RevValid_o       (rev_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (sw !== '0) begin errors++; $display("FAIL reset_switches: got %h expected 0", sw); end
        checks++; if (fail !== '0) begin errors++; $display("FAIL reset_fail: got %h expected 0", fail); end
        checks++; if (fail_lat !== '0) begin errors++; $display("FAIL reset_fail_latched: got %h expected 0", fail_lat); end
        checks++; if (sw_evt !== 1'b0) begin errors++; $display("FAIL reset_event: got %b expected 0", sw_evt); end
        checks++; if (mreset !== 1'b1) begin errors++; $display("FAIL reset_mreset: got %b expected 1", mreset); end
        checks++; if (rev_valid !== 1'b0) begin errors++; $display("FAIL reset_rev_valid: got %b expected 0", rev_valid); end
        checks++; if (pcb_rev !== 4'h0) begin errors++; $display("FAIL reset_pcb_rev: got %h expected 0", pcb_rev); end
        $display("test_reset: done");
    endtask

    // Releases reset just after an edge and counts edges until MReset_o drops.
    task automatic test_reset_release(input logic [3:0] exp_rev);
        int drop;
        drop  = 0;
        rst_n = 1'b1;
        for (int n = 1; n <= RC + 50 && drop == 0; n++) begin
            tick();
            if (n == RSD) begin
                checks++; if (rev_valid !== 1'b0) begin errors++; $display("FAIL rev_valid_early: got %b expected 0 at cycle %0d", rev_valid, n); end
            end
            if (n == RSD + 1) begin
                checks++; if (rev_valid !== 1'b1) begin errors++; $display("FAIL rev_valid_rise: got %b expected 1 at cycle %0d", rev_valid, n); end
                checks++; if (pcb_rev !== exp_rev) begin errors++; $display("FAIL rev_capture: got %h expected %h", pcb_rev, exp_rev); end
            end
            if (mreset === 1'b0) drop = n;
        end
        checks++; if (drop != RC) begin errors++; $display("FAIL mreset_release_len: got %0d expected %0d (0 = never dropped)", drop, RC); end
        $display("test_reset_release: MReset_o dropped after %0d cycles, rev=%h", drop, pcb_rev);
    endtask

    task automatic test_rev_hold();
        rev_raw = 4'b0110;
        repeat (5) tick();
        checks++; if (pcb_rev !== 4'b1010) begin errors++; $display("FAIL rev_hold: got %h expected a", pcb_rev); end
        checks++; if (rev_valid !== 1'b1) begin errors++; $display("FAIL rev_hold_valid: got %b expected 1", rev_valid); end
        $display("test_rev_hold: done");
    endtask

    task automatic test_debounce();
        logic [NSW-1:0] exp_sw;
        logic           exp_ev;
        raw_sw[5] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_sw = (k >= DEB + 2) ? 32'h0000_0020 : 32'h0;
            exp_ev = (k == DEB + 3);
            checks++; if (sw !== exp_sw) begin errors++; $display("FAIL debounce_sw k=%0d: got %h expected %h", k, sw, exp_sw); end
            checks++; if (sw_evt !== exp_ev) begin errors++; $display("FAIL debounce_event k=%0d: got %b expected %b", k, sw_evt, exp_ev); end
        end
        // 3-cycle glitch back to the idle pin level
        raw_sw[5] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 3) raw_sw[5] = 1'b0;
            checks++; if (sw !== 32'h0000_0020) begin errors++; $display("FAIL glitch_sw k=%0d: got %h expected 00000020", k, sw); end
            checks++; if (sw_evt !== 1'b0) begin errors++; $display("FAIL glitch_event k=%0d: got %b expected 0", k, sw_evt); end
        end
        raw_sw[5] = 1'b1;
        repeat (10) tick();
        checks++; if (sw !== '0) begin errors++; $display("FAIL debounce_restore: got %h expected 0", sw); end
        $display("test_debounce: done");
    endtask

    task automatic test_multi_event();
        int ev_count;
        ev_count   = 0;
        raw_sw[0]  = 1'b0;
        raw_sw[31] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (sw_evt === 1'b1) ev_count++;
        end
        checks++; if (ev_count != 1) begin errors++; $display("FAIL multi_event_count: got %0d expected 1", ev_count); end
        checks++; if (sw !== 32'h8000_0001) begin errors++; $display("FAIL multi_event_sw: got %h expected 80000001", sw); end
        raw_sw = '1;
        repeat (10) tick();
        $display("test_multi_event: %0d strobes", ev_count);
    endtask

    task automatic test_fail_latch();
        raw_fail[3] = 1'b0;
        repeat (9) tick();
        checks++; if (fail !== 16'h0008) begin errors++; $display("FAIL fail_live: got %h expected 0008", fail); end
        checks++; if (fail_lat !== 16'h0008) begin errors++; $display("FAIL fail_latched_set: got %h expected 0008", fail_lat); end
        checks++; if (deact !== 16'h0008) begin errors++; $display("FAIL auto_deactivate: got %h expected 0008", deact); end
        fail_clr[3] = 1'b1;
        tick();
        fail_clr = '0;
        tick();
        checks++; if (fail_lat !== 16'h0008) begin errors++; $display("FAIL clear_while_present: got %h expected 0008", fail_lat); end
        raw_fail[3] = 1'b1;
        repeat (9) tick();
        checks++; if (fail !== 16'h0) begin errors++; $display("FAIL fail_removed: got %h expected 0000", fail); end
        checks++; if (fail_lat !== 16'h0008) begin errors++; $display("FAIL fail_sticky: got %h expected 0008", fail_lat); end
        checks++; if (deact !== 16'h0008) begin errors++; $display("FAIL deact_sticky: got %h expected 0008", deact); end
        fail_clr[3] = 1'b1;
        tick();
        fail_clr = '0;
        checks++; if (fail_lat !== 16'h0) begin errors++; $display("FAIL fail_cleared: got %h expected 0000", fail_lat); end
        checks++; if (deact !== 16'h0008) begin errors++; $display("FAIL deact_lag: got %h expected 0008", deact); end
        tick();
        checks++; if (deact !== 16'h0) begin errors++; $display("FAIL deact_cleared: got %h expected 0000", deact); end
        deact_req = 16'h0100;
        tick();
        checks++; if (deact !== 16'h0100) begin errors++; $display("FAIL deact_request: got %h expected 0100", deact); end
        deact_req = '0;
        tick();
        checks++; if (deact !== 16'h0) begin errors++; $display("FAIL deact_request_off: got %h expected 0000", deact); end
        $display("test_fail_latch: done");
    endtask

    task automatic test_set_clear_same_cycle();
        raw_fail[3] = 1'b0;
        repeat (DEB + 2) tick();
        checks++; if (fail !== 16'h0008) begin errors++; $display("FAIL setclr_fail_rise: got %h expected 0008", fail); end
        checks++; if (fail_lat !== 16'h0) begin errors++; $display("FAIL setclr_pre_latch: got %h expected 0000", fail_lat); end
        fail_clr[3] = 1'b1;
        tick();
        fail_clr = '0;
        checks++; if (fail_lat !== 16'h0008) begin errors++; $display("FAIL setclr_set_wins: got %h expected 0008", fail_lat); end
        raw_fail[3] = 1'b1;
        repeat (9) tick();
        fail_clr[3] = 1'b1;
        tick();
        fail_clr = '0;
        repeat (2) tick();
        checks++; if (fail_lat !== 16'h0) begin errors++; $display("FAIL setclr_cleanup: got %h expected 0000", fail_lat); end
        $display("test_set_clear_same_cycle: done");
    endtask

    task automatic test_mreset_retrigger();
        int drop;
        drop = 0;
        checks++; if (mreset !== 1'b0) begin errors++; $display("FAIL retrig_idle: got %b expected 0", mreset); end
        mres_req = 1'b1;
        tick();
        mres_req = 1'b0;
        checks++; if (mreset !== 1'b1) begin errors++; $display("FAIL retrig_assert: got %b expected 1", mreset); end
        for (int j = 1; j <= 1700 && drop == 0; j++) begin
            if (j == 500) mres_req = 1'b1;
            tick();
            mres_req = 1'b0;
            if (mreset === 1'b0) drop = j;
        end
        checks++; if (drop != 500 + RC) begin errors++; $display("FAIL retrig_len: got %0d expected %0d (0 = never dropped)", drop, 500 + RC); end
        $display("test_mreset_retrigger: MReset_o high for %0d cycles", drop);
    endtask

    task automatic test_reset_mid_op();
        raw_fail[3] = 1'b0;
        mres_req = 1'b1;
        tick();
        mres_req = 1'b0;
        repeat (8) tick();
        raw_sw[5] = 1'b0;
        repeat (3) tick();
        checks++; if (fail_lat !== 16'h0008) begin errors++; $display("FAIL midop_pre_latch: got %h expected 0008", fail_lat); end
        checks++; if (mreset !== 1'b1) begin errors++; $display("FAIL midop_pre_mreset: got %b expected 1", mreset); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (sw !== '0) begin errors++; $display("FAIL midop_switches: got %h expected 0", sw); end
        checks++; if (fail !== '0) begin errors++; $display("FAIL midop_fail: got %h expected 0", fail); end
        checks++; if (fail_lat !== '0) begin errors++; $display("FAIL midop_fail_latched: got %h expected 0", fail_lat); end
        checks++; if (sw_evt !== 1'b0) begin errors++; $display("FAIL midop_event: got %b expected 0", sw_evt); end
        checks++; if (mreset !== 1'b1) begin errors++; $display("FAIL midop_mreset: got %b expected 1", mreset); end
        checks++; if (rev_valid !== 1'b0) begin errors++; $display("FAIL midop_rev_valid: got %b expected 0", rev_valid); end
        checks++; if (pcb_rev !== 4'h0) begin errors++; $display("FAIL midop_pcb_rev: got %h expected 0", pcb_rev); end
        raw_sw   = '1;
        raw_fail = '1;
        rev_raw  = 4'b0101;
        repeat (3) tick();
        $display("test_reset_mid_op: async reset applied");
        test_reset_release(4'b0101);
    endtask

    initial begin
        rst_n     = 1'b0;
        raw_sw    = '1;
        raw_fail  = '1;
        fail_clr  = '0;
        deact_req = '0;
        mres_req  = 1'b0;
        rev_raw   = 4'b1010;
        test_reset();
        test_reset_release(4'b1010);
        test_rev_hold();
        test_debounce();
        test_multi_event();
        test_fail_latch();
        test_set_clear_same_cycle();
        test_mreset_retrigger();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
